// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction requests into words
// and writes them sequentially into a 256-word instruction memory image.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [31:0] im_data,
  output logic        err,
  output logic        full,
  output logic [8:0]  count
);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    WRITE,
    FULL
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        full_q, full_d;
  logic [4:0]  op_q, op_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] imm_q, imm_d;
  logic [25:0] tgt_q, tgt_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] enc_word;
  logic        is_r;
  logic        is_j;
  logic        is_lui;

  assign in_ready = (state_q == IDLE);
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_data  = data_q;
  assign err      = err_q;
  assign full     = full_q;
  assign count    = count_q;

  assign is_r   = (op_q < 5'd5);
  assign is_j   = (op_q == 5'd5) || (op_q == 5'd6);
  assign is_lui = (op_q == 5'd13);

  // Map the registered op select to its opcode/funct and build the word
  always_comb begin
    opcode   = 6'd0;
    funct    = 6'd0;
    enc_word = 32'd0;
    case (op_q)
      5'd0:    funct  = 6'h20;
      5'd1:    funct  = 6'h22;
      5'd2:    funct  = 6'h24;
      5'd3:    funct  = 6'h25;
      5'd4:    funct  = 6'h2A;
      5'd5:    opcode = 6'd2;
      5'd6:    opcode = 6'd3;
      5'd7:    opcode = 6'd4;
      5'd8:    opcode = 6'd5;
      5'd9:    opcode = 6'd8;
      5'd10:   opcode = 6'd10;
      5'd11:   opcode = 6'd12;
      5'd12:   opcode = 6'd13;
      5'd13:   opcode = 6'd15;
      5'd14:   opcode = 6'd35;
      5'd15:   opcode = 6'd43;
      default: opcode = 6'd0;
    endcase
    unique case (1'b1)
      is_r:
        enc_word = {6'd0, rs_q, rt_q, rd_q,
                    5'd0, funct};
      is_j:
        enc_word = {opcode, tgt_q};
      default:
        enc_word = {opcode,
                    is_lui ? 5'd0 : rs_q,
                    rt_q, imm_q};
    endcase
  end

  // Next-state and next-output logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    full_d  = full_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op_sel;
          rs_d  = rs;
          rt_d  = rt;
          rd_d  = rd;
          imm_d = imm;
          tgt_d = target;
          if (op_sel < 5'd16) state_d = ENCODE;
          else                err_d   = 1'b1;
        end
      end
      ENCODE: begin
        state_d = WRITE;
        we_d    = 1'b1;
        addr_d  = count_q[7:0];
        data_d  = enc_word;
      end
      WRITE: begin
        count_d = count_q + 9'd1;
        if (count_q == 9'd255) begin
          state_d = FULL;
          full_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FULL: begin
        full_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      count_d = 9'd0;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      err_d   = 1'b0;
      full_d  = 1'b0;
    end
  end

  // State, output and field registers with immediate async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 9'd0;
      addr_q  <= 8'd0;
      data_q  <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      op_q    <= 5'd0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      imm_q   <= 16'd0;
      tgt_q   <= 26'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      full_q  <= full_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
